// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        EMIT  = 2'd2
    } state_t;

    // Double-dabble nibble adjust: nibbles at or above the threshold get the offset.
    localparam logic [3:0] ADD3_THRESH = 4'd5;
    localparam logic [3:0] ADD3_VAL    = 4'd3;

    // True when DIGITS decimal digits can hold every BIN_W-bit value,
    // i.e. 10^digits > 2^bin_w - 1, which is the same as 10^digits >= 2^bin_w.
    function automatic bit digits_ok(input int bin_w, input int digits);
        longint unsigned p10;
        longint unsigned p2;
        p10 = 1;
        for (int i = 0; i < digits; i++) begin
            if (p10 < 64'd1000000000000000000) p10 = p10 * 10;
        end
        p2 = 64'd1 << bin_w;
        return (p10 >= p2);
    endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// Combinational double-dabble nibble adjust: add 3 when the nibble is 5 or more.
module bcd_add3_cell
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Inputs never exceed 9, so the 4-bit sum cannot wrap.
    assign dout = (din >= ADD3_THRESH) ? (din + ADD3_VAL) : din;

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Serial binary-to-BCD converter: accepts one word, runs double-dabble one
// bit per cycle, then streams the BCD digits most significant first.
//
// Handshakes: a transfer happens on a rising clock edge where valid && ready
// are both high; a source holds its payload stable while valid && !ready.
// in_ready and bcd_valid are decoded from state only, so neither depends
// combinationally on the opposite handshake input.
module bin_to_bcd_serial
    import bcd_pkg::*;
#(
    parameter int BIN_W       = 8,
    parameter int DIGITS      = 3,
    parameter int LZ_SUPPRESS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIN_W-1:0] in_bin,
    output logic             bcd_valid,
    input  logic             bcd_ready,
    output logic [3:0]       bcd_digit,
    output logic             bcd_last,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BCD_W = 4 * DIGITS;

    if (!digits_ok(BIN_W, DIGITS)) begin : g_bad_digits
        $error("bin_to_bcd_serial: DIGITS too small for BIN_W");
    end

    state_t                   state;
    logic [BIN_W-1:0]         bin_sr;
    logic [BCD_W-1:0]         bcd_sr;
    logic [CNT_W-1:0]         cnt;
    logic [IDX_W-1:0]         idx;
    logic [BCD_W-1:0]         bcd_adj;
    logic [BCD_W+BIN_W-1:0]   shifted;
    logic [IDX_W-1:0]         top_idx;

    // One adjust cell per BCD nibble.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_cell u_cell (
            .din  (bcd_sr[4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );
    end

    // Adjusted nibbles and the binary word shift left together as one register.
    assign shifted = {bcd_adj, bin_sr} << 1;

    // Highest nonzero nibble of the post-shift BCD value (0 when all zero).
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (shifted[BIN_W + 4*i +: 4] != 4'd0) top_idx = IDX_W'(i);
        end
    end

    // Controller: load, BIN_W shift steps, then one digit per handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            bin_sr <= '0;
            bcd_sr <= '0;
            cnt    <= '0;
            idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_sr <= in_bin;
                        bcd_sr <= '0;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_sr <= shifted[BCD_W+BIN_W-1:BIN_W];
                    bin_sr <= shifted[BIN_W-1:0];
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        state <= EMIT;
                        idx   <= (LZ_SUPPRESS != 0) ? top_idx : IDX_W'(DIGITS - 1);
                    end
                end
                EMIT: begin
                    if (bcd_ready) begin
                        if (idx == '0) state <= IDLE;
                        else           idx   <= idx - IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Select the current digit; zero outside EMIT.
    always_comb begin
        bcd_digit = 4'd0;
        if (state == EMIT) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx == IDX_W'(i)) bcd_digit = bcd_sr[4*i +: 4];
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign bcd_valid = (state == EMIT);
    assign bcd_last  = (state == EMIT) && (idx == '0);
    assign dbg_state = state;

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Bench for bin_to_bcd_serial: two instances (leading zeros kept / suppressed)
// checked every cycle against a decimal-arithmetic model.
module tb_bin_to_bcd_serial;

    localparam int BIN_W  = 8;
    localparam int DIGITS = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic             in_valid  [2];
    logic             in_ready  [2];
    logic [BIN_W-1:0] in_bin    [2];
    logic             bcd_valid [2];
    logic             bcd_ready [2];
    logic [3:0]       bcd_digit [2];
    logic             bcd_last  [2];
    logic [1:0]       dbg_state [2];

    int tests_run = 0;
    int fails     = 0;

    logic [4:0] got_q0[$];
    logic [4:0] got_q1[$];
    int         gotc_q0[$];
    bit         rand_rdy = 1'b0;

    bin_to_bcd_serial #(.BIN_W(BIN_W), .DIGITS(DIGITS), .LZ_SUPPRESS(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_bin(in_bin[0]),
        .bcd_valid(bcd_valid[0]), .bcd_ready(bcd_ready[0]),
        .bcd_digit(bcd_digit[0]), .bcd_last(bcd_last[0]), .dbg_state(dbg_state[0])
    );

    bin_to_bcd_serial #(.BIN_W(BIN_W), .DIGITS(DIGITS), .LZ_SUPPRESS(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_bin(in_bin[1]),
        .bcd_valid(bcd_valid[1]), .bcd_ready(bcd_ready[1]),
        .bcd_digit(bcd_digit[1]), .bcd_last(bcd_last[1]), .dbg_state(dbg_state[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Decimal digits of v, most significant first, each tagged with its last flag.
    function automatic int mk_digits(input int v, input bit lz, output logic [4:0] seq[3]);
        int d[3];
        int start;
        int n;
        for (int i = 0; i < 3; i++) seq[i] = '0;
        d[2] = v / 100;
        d[1] = (v / 10) % 10;
        d[0] = v % 10;
        start = 2;
        if (lz) while (start > 0 && d[start] == 0) start--;
        n = 0;
        for (int i = start; i >= 0; i--) begin
            seq[n] = {(i == 0), 4'(d[i])};
            n++;
        end
        return n;
    endfunction

    // ---------------- model + scoreboard, one per instance ----------------
    for (genvar g = 0; g < 2; g++) begin : mon
        logic [4:0] exp_q[$];
        bit busy    = 1'b0;
        int acc_cyc = 0;
        int acc_val = 0;
        int recon   = 0;

        always @(negedge clk) begin
            logic [4:0] seq[3];
            int         n;
            bit         exp_v;
            if (rst) begin
                exp_q.delete();
                busy = 1'b0;
            end else begin
                chk($sformatf("in_ready%0d", g), 32'(in_ready[g]), 32'(!busy));
                exp_v = busy && (cyc >= acc_cyc + BIN_W + 1);
                chk($sformatf("bcd_valid%0d", g), 32'(bcd_valid[g]), 32'(exp_v));
                if (bcd_valid[g] && exp_v) begin
                    chk($sformatf("digit_expected%0d", g), 32'(exp_q.size() > 0), 32'd1);
                    chk($sformatf("digit_le_9_%0d", g), 32'(bcd_digit[g] <= 4'd9), 32'd1);
                    if (exp_q.size() > 0) begin
                        chk($sformatf("bcd_digit%0d", g), 32'(bcd_digit[g]), 32'(exp_q[0][3:0]));
                        chk($sformatf("bcd_last%0d", g), 32'(bcd_last[g]), 32'(exp_q[0][4]));
                        if (bcd_ready[g]) begin
                            if (g == 0) begin
                                got_q0.push_back({bcd_last[g], bcd_digit[g]});
                                gotc_q0.push_back(cyc - acc_cyc);
                            end else begin
                                got_q1.push_back({bcd_last[g], bcd_digit[g]});
                            end
                            recon = recon * 10 + int'(bcd_digit[g]);
                            if (exp_q[0][4]) begin
                                chk($sformatf("recon%0d", g), 32'(recon), 32'(acc_val));
                                busy = 1'b0;
                            end
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (in_valid[g] && in_ready[g]) begin
                    chk($sformatf("accept_only_idle%0d", g), 32'(busy), 32'd0);
                    exp_q.delete();
                    n = mk_digits(int'(in_bin[g]), (g == 1), seq);
                    for (int i = 0; i < n; i++) exp_q.push_back(seq[i]);
                    busy    = 1'b1;
                    acc_cyc = cyc;
                    acc_val = int'(in_bin[g]);
                    recon   = 0;
                end
            end
        end
    end

    // Random downstream backpressure while enabled.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            for (int d = 0; d < 2; d++) bcd_ready[d] = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int d, input int v, input bit hold);
        int t;
        t = 0;
        @(posedge clk); #1;
        in_bin[d]   = BIN_W'(v);
        in_valid[d] = 1'b1;
        @(negedge clk);
        while (!in_ready[d] && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("send_timeout", 32'(t < 200), 32'd1);
        @(posedge clk); #1;
        if (!hold) in_valid[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready[d] && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", 32'(t < 300), 32'd1);
    endtask

    task automatic check_seq(input string name, input int d, input int n, input logic [4:0] e[3]);
        logic [4:0] q[$];
        if (d == 0) q = got_q0;
        else        q = got_q1;
        chk({name, "_len"}, 32'(q.size()), 32'(n));
        for (int i = 0; i < n && i < q.size(); i++) chk({name, "_dig"}, 32'(q[i]), 32'(e[i]));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_bin[d]    = '0;
            bcd_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready",  32'(in_ready[d]),  32'd1);
            chk("rst_bcd_valid", 32'(bcd_valid[d]), 32'd0);
            chk("rst_bcd_digit", 32'(bcd_digit[d]), 32'd0);
            chk("rst_bcd_last",  32'(bcd_last[d]),  32'd0);
            chk("rst_state",     32'(dbg_state[d]), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // 255: digits 2,5,5 in cycles 9..11, in_ready back in cycle 12.
        got_q0.delete(); gotc_q0.delete();
        send(0, 255, 1'b0);
        repeat (11) @(negedge clk);
        chk("d255_ready_c11", 32'(in_ready[0]), 32'd0);
        @(negedge clk);
        chk("d255_ready_c12", 32'(in_ready[0]), 32'd1);
        check_seq("d255", 0, 3, '{5'h02, 5'h05, 5'h15});
        chk("d255_len_t", 32'(gotc_q0.size()), 32'd3);
        if (gotc_q0.size() == 3) begin
            chk("d255_t0", 32'(gotc_q0[0]), 32'd9);
            chk("d255_t2", 32'(gotc_q0[2]), 32'd11);
        end

        // Zero with and without suppression.
        got_q0.delete(); got_q1.delete();
        send(0, 0, 1'b0); wait_idle(0);
        send(1, 0, 1'b0); wait_idle(1);
        check_seq("zero_lz0", 0, 3, '{5'h00, 5'h00, 5'h10});
        check_seq("zero_lz1", 1, 1, '{5'h10, 5'h00, 5'h00});

        got_q1.delete();
        send(1, 9, 1'b0); wait_idle(1);
        check_seq("lz_9", 1, 1, '{5'h19, 5'h00, 5'h00});
        got_q1.delete();
        send(1, 100, 1'b0); wait_idle(1);
        check_seq("lz_100", 1, 3, '{5'h01, 5'h00, 5'h10});

        // 128 with three stall cycles on every digit.
        got_q0.delete();
        send(0, 128, 1'b0);
        bcd_ready[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            int t;
            t = 0;
            @(negedge clk);
            while (!bcd_valid[0] && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk("stall_timeout", 32'(t < 100), 32'd1);
            repeat (3) @(posedge clk);
            #1 bcd_ready[0] = 1'b1;
            @(posedge clk);
            #1 bcd_ready[0] = 1'b0;
        end
        bcd_ready[0] = 1'b1;
        wait_idle(0);
        check_seq("stall_128", 0, 3, '{5'h01, 5'h02, 5'h18});

        // Reset during SHIFT aborts the word; the next word converts normally.
        got_q0.delete();
        send(0, 200, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("abort_no_digits", 32'(got_q0.size()), 32'd0);
        send(0, 37, 1'b0); wait_idle(0);
        check_seq("after_rst_37", 0, 3, '{5'h00, 5'h03, 5'h17});

        // Full sweep, in_valid held high throughout, random backpressure.
        rand_rdy = 1'b1;
        for (int v = 0; v < 256; v++) send(0, v, (v != 255));
        wait_idle(0);

        // Random words on the suppressing instance.
        for (int i = 0; i < 40; i++) send(1, int'($urandom_range(0, 255)), (i != 39));
        wait_idle(1);
        rand_rdy = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
